// File: rtl/fma_normalizer_rounder_pkg.sv
// fma_pkg: shared constants, types and helpers for the FMA back end
// (normaliser / rounder).
//   PARM_*       : float format and the width of the sum magnitude
//   UNIT_BIT     : magnitude bit that carries the 1.0 position
//   EXP_W        : internal signed exponent width; headroom keeps shifts and the
//                  rounding carry from wrapping
//   norm_state_e : controller states
//   flags_t      : {overflow, underflow, inexact}
//   shr_sticky   : right shift that also returns the OR of the dropped bits
package fma_pkg;

   localparam int PARM_EXP  = 8;
   localparam int PARM_MANT = 23;
   localparam int PARM_BIAS = 127;
   localparam int PARM_SUM  = 76;
   localparam int UNIT_BIT  = 73;
   localparam int EXP_W     = PARM_EXP + 4;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} norm_state_e;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } flags_t;

   // Returns {v >> sh, |dropped_bits}. A non-positive sh leaves v unchanged.
   function automatic logic [PARM_SUM:0] shr_sticky(input logic [PARM_SUM-1:0] v,
                                                   input int sh);
      logic [PARM_SUM-1:0] res;
      logic                lost;
      if (sh <= 0) begin
         res  = v;
         lost = 1'b0;
      end else if (sh >= PARM_SUM) begin
         res  = '0;
         lost = |v;
      end else begin
         res  = v >> sh;
         lost = |(v << (PARM_SUM - sh));
      end
      return {res, lost};
   endfunction

endpackage

// File: rtl/fma_normalizer_rounder_lzc.sv
// leading_zero_counter: counts the zeros above the most significant set bit.
//   vec      : input word
//   count    : number of leading zeros (WIDTH when vec is all zero)
//   all_zero : vec == 0
module leading_zero_counter #(
   parameter int WIDTH = 76,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [CNT_W-1:0] count,
   output logic             all_zero
);

   // The loop runs upward, so the highest set bit has the last word.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

   assign all_zero = ~|vec;

endmodule

// File: rtl/fma_normalizer_rounder.sv
// fma_normalizer_rounder: normalises the un-normalised FMA sum magnitude,
// rounds it to nearest-even and packs the single-precision result.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   In_valid_i/In_ready_o   : input handshake (the block accepts only in IDLE)
//   Mag_i, Exp_i            : magnitude (unit at bit 73) and signed biased exponent
//   Sign_i, Sticky_i        : result sign and the OR of bits dropped upstream
//   Out_valid_o/Out_ready_i : output handshake (the result is held in DONE)
//   Result_o, Flags_o       : packed float and {overflow, underflow, inexact}
// Macro NORM_LZC_FAST_EN: when defined, normalisation is one barrel-shift
// cycle. When it is undefined, the iterative 16/4/1 shifter is used.
//
// state | meaning
// IDLE  | ready for an operand
// NORM  | shifting the magnitude toward the unit bit / the denormal floor
// ROUND | round to nearest-even and pack
// DONE  | result valid, waiting for Out_ready_i
module fma_normalizer_rounder
   import fma_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        In_valid_i,
   output logic                        In_ready_o,
   input  logic [PARM_SUM-1:0]         Mag_i,
   input  logic [PARM_EXP+1:0]         Exp_i,
   input  logic                        Sign_i,
   input  logic                        Sticky_i,
   output logic                        Out_valid_o,
   input  logic                        Out_ready_i,
   output logic [PARM_EXP+PARM_MANT:0] Result_o,
   output logic [2:0]                  Flags_o
);

   localparam int MANT_LSB  = UNIT_BIT - PARM_MANT;
   localparam int GUARD_BIT = MANT_LSB - 1;
   localparam int EXP_MAX   = (1 << PARM_EXP) - 1;

   norm_state_e             state;
   logic [PARM_SUM-1:0]     mag;
   logic signed [EXP_W-1:0] expo;
   logic                    sign, sticky, zero;

   logic [PARM_SUM-1:0]     nrm_mag, sh_mag;
   logic signed [EXP_W-1:0] nrm_exp;
   logic                    nrm_sticky, nrm_done, sh_lost;
   int                      e_cur, lsh;

`ifdef NORM_LZC_FAST_EN
   localparam int LZ_W = $clog2(PARM_SUM + 1);
   logic [LZ_W-1:0] lz;
   logic            mag_zero;

   leading_zero_counter #(.WIDTH(PARM_SUM), .CNT_W(LZ_W)) u_lzc (
      .vec      (mag),
      .count    (lz),
      .all_zero (mag_zero)
   );

   // The signed shift that puts the leading one on the unit bit. It is clamped
   // so that the exponent never drops below 1. A negative value is a right
   // shift, which covers both the carry headroom and the denormal range.
   always_comb begin
      e_cur = int'(expo);
      lsh   = UNIT_BIT - (PARM_SUM - 1 - int'(lz));
      if (lsh > e_cur - 1) lsh = e_cur - 1;
      {sh_mag, sh_lost} = shr_sticky(mag, -lsh);
      nrm_mag    = mag;
      nrm_exp    = expo;
      nrm_sticky = sticky;
      nrm_done   = 1'b1;
      if (!mag_zero) begin
         if (lsh >= 0) begin
            nrm_mag = mag << lsh;
         end else begin
            nrm_mag    = sh_mag;
            nrm_sticky = sticky | sh_lost;
         end
         nrm_exp = EXP_W'(e_cur - lsh);
      end
   end
`else
   int sh_amt;

   always_comb begin
      e_cur      = int'(expo);
      sh_amt     = 0;
      lsh        = 0;
      nrm_mag    = mag;
      nrm_exp    = expo;
      nrm_sticky = sticky;
      nrm_done   = 1'b0;
      if (mag[PARM_SUM-1:UNIT_BIT+1] != '0) begin
         sh_amt = mag[PARM_SUM-1] ? 2 : 1;
      end else if (mag == '0) begin
         // Only the sticky bit is left. There is nothing to normalise.
         nrm_done = 1'b1;
      end else if (e_cur < 1) begin
         sh_amt = (1 - e_cur > 16) ? 16 : 1 - e_cur;
      end else if (mag[UNIT_BIT] || e_cur == 1) begin
         nrm_done = 1'b1;
      end else begin
         lsh = (mag[UNIT_BIT -: 16] == '0) ? 16 :
               (mag[UNIT_BIT -: 4]  == '0) ? 4  : 1;
         if (lsh > e_cur - 1) lsh = e_cur - 1;
         nrm_mag = mag << lsh;
         nrm_exp = EXP_W'(e_cur - lsh);
      end
      {sh_mag, sh_lost} = shr_sticky(mag, sh_amt);
      if (sh_amt > 0) begin
         nrm_mag    = sh_mag;
         nrm_sticky = sticky | sh_lost;
         nrm_exp    = EXP_W'(e_cur + sh_amt);
         nrm_done   = (sh_mag == '0);
      end
   end
`endif

   logic [PARM_MANT+1:0]        rnd_mant;
   logic                        rnd_guard, rnd_sticky, rnd_inc, rnd_carry, rnd_unit, rnd_inexact;
   logic signed [EXP_W-1:0]     rnd_exp;
   logic [PARM_EXP+PARM_MANT:0] rnd_result;
   flags_t                      rnd_flags;

   always_comb begin
      rnd_guard   = mag[GUARD_BIT];
      rnd_sticky  = (|mag[GUARD_BIT-1:0]) | sticky;
      rnd_inc     = rnd_guard & (rnd_sticky | mag[MANT_LSB]);
      rnd_mant    = {1'b0, mag[UNIT_BIT:MANT_LSB]} + {{(PARM_MANT + 1){1'b0}}, rnd_inc};
      rnd_carry   = rnd_mant[PARM_MANT+1];
      // A carry out leaves the low mantissa bits zero, which is exactly 1.0.
      rnd_unit    = rnd_carry | rnd_mant[PARM_MANT];
      rnd_exp     = expo + {{(EXP_W - 1){1'b0}}, rnd_carry};
      rnd_inexact = rnd_guard | rnd_sticky;
      rnd_result  = '0;
      rnd_flags   = '0;
      if (zero) begin
         rnd_result = '0;
      end else if (rnd_unit && int'(rnd_exp) >= EXP_MAX) begin
         rnd_result         = {sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
         rnd_flags.overflow = 1'b1;
         rnd_flags.inexact  = 1'b1;
      end else begin
         rnd_result = {sign,
                       rnd_unit ? rnd_exp[PARM_EXP-1:0] : {PARM_EXP{1'b0}},
                       rnd_mant[PARM_MANT-1:0]};
         rnd_flags.underflow = ~rnd_unit & rnd_inexact;
         rnd_flags.inexact   = rnd_inexact;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         mag      <= '0;
         expo     <= '0;
         sign     <= 1'b0;
         sticky   <= 1'b0;
         zero     <= 1'b0;
         Result_o <= '0;
         Flags_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (In_valid_i) begin
                  mag    <= Mag_i;
                  expo   <= {{(EXP_W - PARM_EXP - 2){Exp_i[PARM_EXP+1]}}, Exp_i};
                  sign   <= Sign_i;
                  sticky <= Sticky_i;
                  zero   <= (Mag_i == '0) & ~Sticky_i;
                  state  <= ((Mag_i == '0) && !Sticky_i) ? ROUND : NORM;
               end
            end
            NORM: begin
               mag    <= nrm_mag;
               expo   <= nrm_exp;
               sticky <= nrm_sticky;
               if (nrm_done) state <= ROUND;
            end
            ROUND: begin
               Result_o <= rnd_result;
               Flags_o  <= rnd_flags;
               state    <= DONE;
            end
            DONE: begin
               if (Out_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign In_ready_o  = (state == IDLE);
   assign Out_valid_o = (state == DONE);

endmodule

// File: tb/tb_fma_normalizer_rounder.sv
module tb_fma_normalizer_rounder;
   import fma_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        In_valid_i, In_ready_o, Sign_i, Sticky_i, Out_valid_o, Out_ready_i;
   logic [75:0] Mag_i;
   logic [9:0]  Exp_i;
   logic [31:0] Result_o;
   logic [2:0]  Flags_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   fma_normalizer_rounder dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .In_valid_i  (In_valid_i),
      .In_ready_o  (In_ready_o),
      .Mag_i       (Mag_i),
      .Exp_i       (Exp_i),
      .Sign_i      (Sign_i),
      .Sticky_i    (Sticky_i),
      .Out_valid_o (Out_valid_o),
      .Out_ready_i (Out_ready_i),
      .Result_o    (Result_o),
      .Flags_o     (Flags_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: exact value m * 2^(e-200) rounded to the nearest single, ties to even.
   function automatic void ref_model(input logic [75:0] m, input int e, input logic s,
                                     input logic st, output logic [31:0] r, output logic [2:0] f);
      logic [127:0] mm, one;
      logic [24:0]  q;
      logic         g, rest, inex;
      int           p, b, k;
      mm  = 128'(m);
      one = 128'd1;
      p   = -1;
      for (int i = 0; i < 76; i++) if (m[i]) p = i;
      if (p < 0) begin
         r = st ? {s, 31'd0} : 32'd0;
         f = st ? 3'b011 : 3'b000;
         return;
      end
      b = p + e - 73;
      if (b < 1) b = 1;
      k = b - e + 50;
      if (k <= 0) begin
         q = 25'(mm << (-k)); g = 1'b0; rest = st;
      end else if (k > 76) begin
         q = '0; g = 1'b0; rest = 1'b1;
      end else begin
         q    = 25'(mm >> k);
         g    = mm[k-1];
         rest = st | ((k > 1) && ((mm & ((one << (k - 1)) - one)) != '0));
      end
      inex = g | rest;
      if (g && (rest || q[0])) q = q + 25'd1;
      if (q[24]) begin q = q >> 1; b = b + 1; end
      if (q[23] && b >= 255) begin
         r = {s, 8'hFF, 23'd0}; f = 3'b101;
      end else begin
         r = {s, q[23] ? 8'(b) : 8'd0, q[22:0]};
         f = {1'b0, !q[23] && inex, inex};
      end
   endfunction

   task automatic run_txn(input logic [75:0] m, input int e, input logic s, input logic st,
                          output logic [31:0] r, output logic [2:0] f, output int lat);
      int w;
      w = 0;
      while (!In_ready_o && w < 50) begin @(posedge clk_i); #1; w++; end
      if (!In_ready_o) chk("in_ready_wait", 64'(In_ready_o), 64'd1);
      In_valid_i = 1'b1; Mag_i = m; Exp_i = 10'(e); Sign_i = s; Sticky_i = st;
      @(posedge clk_i); #1;
      In_valid_i = 1'b0;
      lat = 0;
      while (!Out_valid_o && lat < 40) begin @(posedge clk_i); #1; lat++; end
      r = Result_o; f = Flags_o;
      Out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      Out_ready_i = 1'b0;
   endtask

   typedef struct {
      logic [75:0] mag;
      int          e;
      logic        s;
      logic        st;
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat_iter;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [75:0] m, input int e, input logic s, input logic st,
                      input logic [31:0] res, input logic [2:0] flg, input int lat);
      vec_t v;
      v.mag = m; v.e = e; v.s = s; v.st = st; v.res = res; v.flg = flg; v.lat_iter = lat;
      vecs.push_back(v);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [75:0] one76, ones25, m;
      logic [95:0] raw;
      logic [31:0] r, rr;
      logic [2:0]  f, rf;
      int          lat, e, exp_lat, hi_cnt;

      rst_ni = 1'b0; In_valid_i = 1'b0; Out_ready_i = 1'b0;
      Mag_i = '0; Exp_i = '0; Sign_i = 1'b0; Sticky_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_in_ready", 64'(In_ready_o), 64'd1);
      chk("rst_out_valid", 64'(Out_valid_o), 64'd0);
      chk("rst_result", 64'(Result_o), 64'd0);
      chk("rst_flags", 64'(Flags_o), 64'd0);
      rst_ni = 1'b1;

      one76  = 76'd1;
      ones25 = (one76 << 25) - one76;
      add(one76 << 73, 127, 0, 0, 32'h3F800000, 3'b000, 2);
      add(one76 << 74, 127, 0, 0, 32'h40000000, 3'b000, 3);
      add(one76 << 75, 127, 0, 0, 32'h40800000, 3'b000, 3);
      add(one76 << 50, 150, 1, 0, 32'hBF800000, 3'b000, 7);
      add(ones25 << 49, 127, 0, 0, 32'h40000000, 3'b001, 2);
      add(ones25 << 49, 254, 0, 0, 32'h7F800000, 3'b101, 2);
      add(one76 << 74, 254, 0, 0, 32'h7F800000, 3'b101, 3);
      add((one76 << 73) | (one76 << 49), 127, 0, 0, 32'h3F800000, 3'b001, 2);
      add(one76 << 73, 0, 0, 0, 32'h00400000, 3'b000, 3);
      add((ones25 >> 1) << 49, 1, 0, 0, 32'h00800000, 3'b001, 2);
      add(one76 << 73, -200, 0, 0, 32'h00000000, 3'b011, 6);
      add('0, 127, 1, 0, 32'h00000000, 3'b000, 1);
      add('0, 127, 1, 1, 32'h80000000, 3'b011, 2);

      foreach (vecs[i]) begin
         run_txn(vecs[i].mag, vecs[i].e, vecs[i].s, vecs[i].st, r, f, lat);
         chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
         chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].flg));
`ifdef NORM_LZC_FAST_EN
         exp_lat = (vecs[i].lat_iter == 1) ? 1 : 2;
`else
         exp_lat = vecs[i].lat_iter;
`endif
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      end

      for (int i = 0; i < 300; i++) begin
         raw = {$urandom(), $urandom(), $urandom()};
         m   = raw[75:0] >> $urandom_range(0, 75);
         if ($urandom_range(0, 19) == 0) m = '0;
         if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 1023)) - 512;
         else e = int'($urandom_range(0, 400)) - 100;
         Sign_i = 1'($urandom());
         run_txn(m, e, 1'($urandom()), (m != '0) ? 1'($urandom()) : 1'b0, r, f, lat);
         ref_model(Mag_i, e, Sign_i, Sticky_i, rr, rf);
         chk($sformatf("rnd%0d_result", i), 64'(r), 64'(rr));
         chk($sformatf("rnd%0d_flags", i), 64'(f), 64'(rf));
`ifdef NORM_LZC_FAST_EN
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'((m == '0) ? 1 : 2));
`else
         if (m == '0) chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd1);
         else chk($sformatf("rnd%0d_latency_bound", i), 64'(lat >= 2 && lat <= 13), 64'd1);
`endif
      end

      // Hold the result in DONE while the consumer stalls.
      In_valid_i = 1'b1; Mag_i = one76 << 73; Exp_i = 10'd127; Sign_i = 1'b0; Sticky_i = 1'b0;
      @(posedge clk_i); #1;
      In_valid_i = 1'b0;
      lat = 0;
      while (!Out_valid_o && lat < 40) begin @(posedge clk_i); #1; lat++; end
      for (int c = 0; c < 5; c++) begin
         chk("hold_out_valid", 64'(Out_valid_o), 64'd1);
         chk("hold_result", 64'(Result_o), 64'h3F800000);
         chk("hold_in_ready", 64'(In_ready_o), 64'd0);
         @(posedge clk_i); #1;
      end
      Out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      Out_ready_i = 1'b0;
      chk("post_hs_out_valid", 64'(Out_valid_o), 64'd0);
      chk("post_hs_in_ready", 64'(In_ready_o), 64'd1);

      // Reset in the middle of a long normalisation.
      In_valid_i = 1'b1; Mag_i = one76 << 50; Exp_i = 10'd150; Sign_i = 1'b1;
      @(posedge clk_i); #1;
      In_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("mid_norm_busy", 64'(In_ready_o), 64'd0);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      chk("abort_in_ready", 64'(In_ready_o), 64'd1);
      chk("abort_out_valid", 64'(Out_valid_o), 64'd0);
      chk("abort_result", 64'(Result_o), 64'd0);
      rst_ni = 1'b1;
      hi_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i); #1;
         if (Out_valid_o) hi_cnt++;
      end
      chk("abort_discarded", 64'(hi_cnt), 64'd0);
      run_txn(one76 << 74, 127, 1, 0, r, f, lat);
      chk("after_abort_result", 64'(r), 64'hC0000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
